// File: rtl/vcpu_mem_pkg.sv
// Shared definitions for the vector CPU data memory and its dump reader:
// the default lane count, the vector word type and the reader state encoding.
package vcpu_mem_pkg;

    // Byte lanes per data-memory vector word.
    localparam int LANES_DEFAULT = 6;

    // One data-memory vector word; lane 0 sits in the lowest byte.
    typedef logic [LANES_DEFAULT-1:0][7:0] vword_t;

    // Dump reader states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_SEND  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/mem_dump_reader.sv
// Streams a run of data-memory vector words out as bytes, lane 0 first.
// Each word is read in a one-cycle FETCH, latched, then sent lane by lane.
//
// Byte stream handshake: byte_valid/byte_data come straight from registers;
// a byte moves only on a rising edge where byte_valid && byte_ready. While
// byte_valid is high and byte_ready is low, byte_data and the lane index are
// held, and byte_valid never drops until that byte has moved.
module mem_dump_reader
    import vcpu_mem_pkg::*;
#(
    parameter int LANES     = LANES_DEFAULT,
    parameter int ADDR_STEP = 1,
    parameter int CNT_W     = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [31:0]            base_addr,
    input  logic [CNT_W-1:0]       word_count,
    output logic [31:0]            A,
    output logic                   WE,
    input  logic [LANES-1:0][7:0]  RD,
    output logic [7:0]             byte_data,
    output logic                   byte_valid,
    input  logic                   byte_ready,
    output logic                   busy,
    output logic                   done,
    output state_t                 o_dbg_state
);

    localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;

    state_t                 r_state;
    logic [31:0]            r_addr;
    logic [CNT_W-1:0]       r_remaining;
    logic [LANE_W-1:0]      r_lane;
    logic [LANES-1:0][7:0]  r_vec;

    logic                   w_send;
    logic                   w_xfer;
    logic                   w_last_lane;

    assign w_send      = (r_state == ST_SEND);
    assign w_xfer      = w_send && byte_ready;
    assign w_last_lane = (r_lane == LANE_W'(LANES - 1));

    // Dump sequencer: capture the request, latch one word per FETCH, walk its lanes in SEND.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_addr      <= '0;
            r_remaining <= '0;
            r_lane      <= '0;
            r_vec       <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_addr      <= base_addr;
                        r_remaining <= word_count;
                        r_lane      <= '0;
                        r_state     <= (word_count != '0) ? ST_FETCH : ST_DONE;
                    end
                end
                ST_FETCH: begin
                    // RD is only trusted here, while A has been stable all cycle.
                    r_vec   <= RD;
                    r_lane  <= '0;
                    r_state <= ST_SEND;
                end
                ST_SEND: begin
                    if (w_xfer) begin
                        if (w_last_lane) begin
                            r_lane      <= '0;
                            r_remaining <= r_remaining - CNT_W'(1);
                            // Address arithmetic is plain modulo 2^32.
                            r_addr      <= r_addr + 32'(ADDR_STEP);
                            r_state     <= (r_remaining == CNT_W'(1)) ? ST_DONE : ST_FETCH;
                        end else begin
                            r_lane <= r_lane + LANE_W'(1);
                        end
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Outputs are pure decodes of registered state, so they never glitch on inputs.
    assign A           = r_addr;
    assign WE          = 1'b0;
    assign byte_valid  = w_send;
    assign byte_data   = w_send ? r_vec[r_lane] : 8'h00;
    assign busy        = (r_state != ST_IDLE);
    assign done        = (r_state == ST_DONE);
    assign o_dbg_state = r_state;

endmodule
